// File: rtl/fp_mul_if.sv
// fp_mul_if: operand/result handshake bundle for the pipelined FP multiplier.
interface fp_mul_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_z;
   logic [3:0]   out_flags;
   modport master(output in_valid, in_a, in_b, out_ready,
                  input in_ready, out_valid, out_z, out_flags);
   modport slave(input in_valid, in_a, in_b, out_ready,
                 output in_ready, out_valid, out_z, out_flags);
endinterface

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage IEEE-754-style multiplier, RNE rounding, DAZ/FTZ, flags {invalid, overflow, underflow, inexact}.
module fp_mul_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input logic    clk,
   input logic    rst,
   fp_mul_if.slave bus
);
   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int BIAS = 2 ** (EXP_W - 1) - 1;
   localparam int EMAX = 2 ** EXP_W - 1;
   localparam int EW2  = EXP_W + 2;
   localparam int PW   = 2 * MAN_W + 2;
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   logic adv;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, any_nan, any_inf, any_zero, snan, sgn, spec;
   logic [W-1:0] spec_z;
   logic [3:0] spec_f;
   logic [EW2-1:0] esum;
   logic v1, s1, sp1;
   logic [EW2-1:0] e1;
   logic [MAN_W:0] ma1, mb1;
   logic [W-1:0] spz1;
   logic [3:0] spf1;
   logic v2, s2, sp2;
   logic [EW2-1:0] e2;
   logic [PW-1:0] p2;
   logic [W-1:0] spz2;
   logic [3:0] spf2;
   logic [PW-1:0] nrm;
   logic [MAN_W-1:0] frac, frac_r;
   logic guard, sticky, rnd, cy, ovf, unf;
   logic [EW2-1:0] exp_f;
   logic [W-1:0] res_z;
   logic [3:0] res_f;
   logic ov;
   logic [W-1:0] oz;
   logic [3:0] of;
   assign adv = !ov || bus.out_ready;
   assign bus.in_ready = adv;
   assign bus.out_valid = ov;
   assign bus.out_z = oz;
   assign bus.out_flags = of;
   assign ea = bus.in_a[W-2:MAN_W];
   assign eb = bus.in_b[W-2:MAN_W];
   assign fa = bus.in_a[MAN_W-1:0];
   assign fb = bus.in_b[MAN_W-1:0];
   assign a_nan = &ea && |fa;
   assign b_nan = &eb && |fb;
   assign a_inf = &ea && !(|fa);
   assign b_inf = &eb && !(|fb);
   // a zero exponent covers subnormals too: they are flushed to zero on input
   assign a_zero = ~|ea;
   assign b_zero = ~|eb;
   assign any_nan = a_nan || b_nan;
   assign any_inf = a_inf || b_inf;
   assign any_zero = a_zero || b_zero;
   assign snan = (a_nan && !fa[MAN_W-1]) || (b_nan && !fb[MAN_W-1]);
   assign sgn = bus.in_a[W-1] ^ bus.in_b[W-1];
   assign spec = any_nan || any_inf || any_zero;
   assign spec_z = any_nan ? QNAN :
                   (any_inf && any_zero) ? QNAN :
                   any_inf ? {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                   {sgn, {(W-1){1'b0}}};
   assign spec_f = any_nan ? {snan, 3'b000} : (any_inf && any_zero) ? 4'b1000 : 4'b0000;
   assign esum = EW2'(ea) + EW2'(eb) - EW2'(BIAS);
   assign nrm = p2[PW-1] ? p2 : p2 << 1;
   assign frac = nrm[PW-2:MAN_W+1];
   assign guard = nrm[MAN_W];
   assign sticky = |nrm[MAN_W-1:0];
   assign rnd = guard && (sticky || frac[0]);
   assign {cy, frac_r} = {1'b0, frac} + (MAN_W+1)'(rnd);
   assign exp_f = e2 + EW2'(p2[PW-1]) + EW2'(cy);
   assign ovf = !exp_f[EW2-1] && (exp_f[EW2-2:0] >= (EW2-1)'(EMAX));
   assign unf = exp_f[EW2-1] || (exp_f == '0);
   assign res_z = sp2 ? spz2 :
                  ovf ? {s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                  unf ? {s2, {(W-1){1'b0}}} :
                  {s2, exp_f[EXP_W-1:0], frac_r};
   assign res_f = sp2 ? spf2 : ovf ? 4'b0101 : unf ? 4'b0011 : {3'b000, guard || sticky};
   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         ov <= 1'b0;
         oz <= '0;
         of <= '0;
      end else if (adv) begin
         v1 <= bus.in_valid;
         s1 <= sgn;
         e1 <= esum;
         ma1 <= {1'b1, fa};
         mb1 <= {1'b1, fb};
         sp1 <= spec;
         spz1 <= spec_z;
         spf1 <= spec_f;
         v2 <= v1;
         s2 <= s1;
         e2 <= e1;
         p2 <= PW'(ma1) * PW'(mb1);
         sp2 <= sp1;
         spz2 <= spz1;
         spf2 <= spf1;
         ov <= v2;
         oz <= res_z;
         of <= res_f;
      end
   end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed and backpressure checks of fp_mul_pipe in single and half precision.
module tb_fp_mul_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   bit chk_lat = 1'b1;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   fp_mul_if #(.EXP_W(8), .MAN_W(23)) s ();
   fp_mul_if #(.EXP_W(5), .MAN_W(10)) h ();
   fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut_s (.clk(clk), .rst(rst), .bus(s));
   fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .rst(rst), .bus(h));
   typedef struct {
      logic [35:0] r;
      int          acc;
   } exp_t;
   exp_t q[$];
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      logic sg;
      int ea, eb, e, sh;
      logic [22:0] fa, fb;
      longint p, qq, r, hf;
      bit an, bn, ai, bi, az, bz;
      sg = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      fa = a[22:0];
      fb = b[22:0];
      an = ea == 255 && fa != 0;
      bn = eb == 255 && fb != 0;
      ai = ea == 255 && fa == 0;
      bi = eb == 255 && fb == 0;
      az = ea == 0;
      bz = eb == 0;
      if (an || bn) return {32'h7FC00000, 1'((an && !fa[22]) || (bn && !fb[22])), 3'b000};
      if ((ai || bi) && (az || bz)) return {32'h7FC00000, 4'b1000};
      if (ai || bi) return {sg, 8'hFF, 23'h0, 4'b0000};
      if (az || bz) return {sg, 31'h0, 4'b0000};
      p = longint'({1'b1, fa}) * longint'({1'b1, fb});
      sh = (p >= (longint'(1) << 47)) ? 24 : 23;
      e = ea + eb - 127 + sh - 23;
      qq = p >> sh;
      r = p - (qq << sh);
      hf = longint'(1) << (sh - 1);
      if (r > hf || (r == hf && qq[0])) qq++;
      if (qq == (longint'(1) << 24)) begin
         qq = qq >> 1;
         e++;
      end
      if (e >= 255) return {sg, 8'hFF, 23'h0, 4'b0101};
      if (e <= 0) return {sg, 31'h0, 4'b0011};
      return {sg, 8'(e), 23'(qq), 3'b000, 1'(r != 0)};
   endfunction
   // every handshake is observed at the falling edge, away from the active edge
   bit prev_stall = 1'b0;
   logic [31:0] pz;
   logic [3:0] pf;
   always @(negedge clk) begin
      if (rst) prev_stall = 1'b0;
      else begin
         if (prev_stall) begin
            chk("hold_z", 64'(s.out_z), 64'(pz));
            chk("hold_flags", 64'(s.out_flags), 64'(pf));
         end
         if (s.out_valid && !s.out_ready) chk("in_ready_stall", 64'(s.in_ready), 64'd0);
         if (s.out_valid && s.out_ready) begin
            if (q.size() == 0) chk("stale_result", 64'(s.out_valid), 64'd0);
            else begin
               exp_t e;
               e = q.pop_front();
               chk("result", 64'({s.out_z, s.out_flags}), 64'(e.r));
               if (chk_lat) chk("latency", 64'(cyc - e.acc), 64'd3);
            end
         end
         prev_stall = s.out_valid && !s.out_ready;
         pz = s.out_z;
         pf = s.out_flags;
      end
   end
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [35:0] e);
      bit ok = 1'b0;
      s.in_valid = 1'b1;
      s.in_a = a;
      s.in_b = b;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = s.in_ready;
         if (ok) q.push_back('{r: e, acc: cyc});
         @(posedge clk);
         #1;
      end
      if (!ok) chk("accept_timeout", 64'(ok), 64'd1);
   endtask
   task automatic drain();
      for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
      #1;
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask
   task automatic hsend(input logic [15:0] a, input logic [15:0] b, input logic [15:0] z, input logic [3:0] f);
      h.in_valid = 1'b1;
      h.in_a = a;
      h.in_b = b;
      @(negedge clk);
      chk("h_in_ready", 64'(h.in_ready), 64'd1);
      @(posedge clk);
      #1;
      h.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("h_out_valid", 64'(h.out_valid), 64'd1);
      chk("h_result", 64'({h.out_z, h.out_flags}), 64'({z, f}));
   endtask
   logic [31:0] da[9];
   logic [31:0] db[9];
   logic [35:0] de[9];
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [31:0] ra, rb;
      da = '{32'h3FC00000, 32'h3F800001, 32'h7F800000, 32'hFF800000, 32'h7F800001,
             32'h80000000, 32'h7F000000, 32'h00800000, 32'h00000001};
      db = '{32'h40000000, 32'h3FC00000, 32'h00000000, 32'h40000000, 32'h3F800000,
             32'h3F800000, 32'h7F000000, 32'h3F000000, 32'h3F800000};
      de = '{{32'h40400000, 4'b0000}, {32'h3FC00002, 4'b0001}, {32'h7FC00000, 4'b1000},
             {32'hFF800000, 4'b0000}, {32'h7FC00000, 4'b1000}, {32'h80000000, 4'b0000},
             {32'h7F800000, 4'b0101}, {32'h00000000, 4'b0011}, {32'h00000000, 4'b0000}};
      s.in_valid = 1'b0;
      s.in_a = '0;
      s.in_b = '0;
      s.out_ready = 1'b1;
      h.in_valid = 1'b0;
      h.in_a = '0;
      h.in_b = '0;
      h.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", 64'(s.out_valid), 64'd0);
      chk("reset_out_z", 64'(s.out_z), 64'd0);
      chk("reset_out_flags", 64'(s.out_flags), 64'd0);
      chk("reset_in_ready", 64'(s.in_ready), 64'd1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 9; i++) send(da[i], db[i], de[i]);
      s.in_valid = 1'b0;
      drain();
      chk_lat = 1'b0;
      fork
         for (int i = 0; i < 6; i++) begin
            ra = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
            rb = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
            send(ra, rb, ref_mul(ra, rb));
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            s.out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            s.out_ready = 1'b1;
         end
      join
      s.in_valid = 1'b0;
      drain();
      chk_lat = 1'b1;
      send(da[0], db[0], de[0]);
      send(da[1], db[1], de[1]);
      s.in_valid = 1'b0;
      q.delete();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_out_valid", 64'(s.out_valid), 64'd0);
      chk("rst_in_ready", 64'(s.in_ready), 64'd1);
      repeat (5) @(posedge clk);
      #1;
      send(da[6], db[6], de[6]);
      s.in_valid = 1'b0;
      drain();
      hsend(16'h3E00, 16'h4000, 16'h4200, 4'b0000);
      hsend(16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
Parametrised IEEE-754-style floating-point multiplier for the ALU datapath, successor to the single-precision combinational multiplier.
- Generalised in exponent/mantissa width; single precision is the default.
- Registered 3-stage pipeline with valid/ready handshake and full backpressure.
- Adds correct round-to-nearest-even with guard/sticky bits, special-value handling and exception flags.

Parameters:
- EXP_W, 8, exponent field width (>=3).
- MAN_W, 23, stored mantissa (fraction) width (>=2).
- Derived, not overridable: W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1; EMAX = 2^EXP_W-1.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept this cycle.
- in_a  in  W  operand A {sign, exp, frac}.
- in_b  in  W  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_z  out  W  product.
- out_flags  out  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Reset: all stage valid bits cleared; out_valid=0, out_z=0, out_flags=0. in_ready=1 from the first cycle after reset is released.
- Pipeline advance: adv = !out_valid || out_ready; in_ready = adv (combinational). When adv=0 every stage, out_z and out_flags hold their values.
- Accept occurs when in_valid && in_ready. Latency is exactly 3 cycles from accept to out_valid when unstalled. Throughput is 1 per cycle. Results emerge in order; none is lost or duplicated.
- Bubbles: an empty stage may be filled regardless of later stages. Holding a bubble against a stalled full stage is allowed but not required. Stage valid bits shift only on adv.
- S1: unpack operands and classify each as zero, subnormal, normal, inf or NaN. Compute sign = a.s ^ b.s. Compute exp sum = ea+eb-BIAS, signed, EXP_W+2 bits. Resolve the special case.
- S2: form the (MAN_W+1)x(MAN_W+1) significand product with the hidden 1, width 2*MAN_W+2.
- S3:
  - If the product MSB is set, shift right 1 and exp+1.
  - Take guard = first dropped bit; sticky = OR of all lower dropped bits.
  - RNE: round up iff guard && (sticky || lsb).
  - A rounding carry-out renormalises: exp+1, frac=0.
  - Pack the result and flags.
- Subnormal inputs are flushed to signed zero (DAZ); no flag is raised for that.
- Special cases, in priority order:
  1. Any NaN input -> canonical qNaN {0, all-ones, 1 followed by zeros}; invalid=1 only if a NaN is signalling (frac MSB=0).
  2. inf × zero -> qNaN, invalid=1.
  3. inf × any -> signed inf.
  4. zero × any -> signed zero.
  No other flags are set in these cases.
- Overflow (final exp >= EMAX): signed inf, overflow=1, inexact=1.
- Underflow (final exp <= 0): signed zero (FTZ), underflow=1, inexact=1.
- inexact = guard||sticky for normal results.
- Reset mid-operation: a rst cycle discards all in-flight operations. out_valid=0 on the next cycle and the discarded results are never emitted.
- Simultaneous in_valid with a stalled output: no accept. The producer must hold in_a/in_b until accepted.

Test Plan:
- Normal and tie-to-even: 0x3FC00000×0x40000000 -> 0x40400000, flags 0. 0x3F800001×0x3FC00000 -> 0x3FC00002, inexact=1, sent back-to-back. Each out_valid appears exactly 3 cycles after its accept.
- Specials: 0x7F800000×0x00000000 -> 0x7FC00000, flags 1000. 0xFF800000×0x40000000 -> 0xFF800000, flags 0000. 0x7F800001×0x3F800000 -> 0x7FC00000, flags 1000. 0x80000000×0x3F800000 -> 0x80000000.
- Range: 0x7F000000×0x7F000000 -> 0x7F800000, flags 0101. 0x00800000×0x3F000000 -> 0x00000000, flags 0011. 0x00000001×0x3F800000 -> 0x00000000, flags 0000.
- Backpressure: stream 6 random operand pairs with out_ready low for cycles 4-8. in_ready falls, out_z/out_flags stay stable while stalled, and all 6 results match the reference model in order.
- Reset mid-flight: accept 2 operations, assert rst for 1 cycle. out_valid=0 the next cycle, no stale result ever appears, and the next accepted op returns after 3 cycles.
- Parameter sweep: EXP_W=5, MAN_W=10 (half precision): 0x3E00×0x4000 -> 0x4200. 0x7BFF×0x7BFF -> 0x7C00, flags 0101.
